// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - MIPS32 fetch-stage program counter sequencer with redirect and halt
module pc_sequencer #(
   parameter int                 ADDR_W   = 12,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_in,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic              halt_req,
   input  logic              resume,
   input  logic [ADDR_W-1:0] addr_to_PC,
   output logic [ADDR_W-1:0] pc_out,
   output logic [ADDR_W-1:0] NPC_addr,
   output logic [ADDR_W-1:0] Branch_addr,
   output logic              select_addr_mux,
   output logic              fetch_valid,
   output logic              flush
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_REDIRECT = 2'd1,
      ST_HALTED   = 2'd2
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] branch_reg;
   logic              pc_load;

   // A taken branch freezes the PC so the redirect cycle can load the target cleanly.
   assign pc_load = ((state == ST_RUN) && !stall_in && !branch_taken) ||
                    (state == ST_REDIRECT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_RUN;
         pc         <= RESET_PC;
         branch_reg <= '0;
      end else begin
         if (pc_load) begin
            pc <= addr_to_PC;
         end
         case (state)
            ST_RUN: begin
               if (branch_taken) begin
                  branch_reg <= branch_target;
                  state      <= ST_REDIRECT;
               end else if (halt_req) begin
                  state <= ST_HALTED;
               end
            end
            ST_REDIRECT: begin
               state <= ST_RUN;
            end
            ST_HALTED: begin
               if (resume) begin
                  state <= ST_RUN;
               end
            end
            default: begin
               state <= ST_RUN;
            end
         endcase
      end
   end

   assign pc_out          = pc;
   assign NPC_addr        = pc + {{(ADDR_W-1){1'b0}}, 1'b1};
   assign Branch_addr     = branch_reg;
   assign select_addr_mux = (state == ST_REDIRECT);
   assign flush           = (state == ST_REDIRECT);
   assign fetch_valid     = (state == ST_RUN) && !stall_in;

endmodule
